lenet5_load_sequencer: RTL and testbench
========================================

Name: lenet5_load_sequencer

Overview:
- Front-end controller for the LeNet-5 top: accepts one valid/ready word stream from the host/AXI4-Lite side and routes it into the engine as weights, then FC biases, then the input feature map.
- Drives the engine's buffer write-enables and clock-enable, waits for the classifier, captures the 4-bit result and reports done/error status.
- Sits between the register/AXI shim and the LeNet-5 top, one per engine instance.

Parameters:
- DATA_BW, 16, width of the stream word and of o_data (≥ max of weight/bias/fmap widths).
- N_WEIGHT, 3220, weight words per full load (conv1 + conv2 + FC).
- N_BIAS, 10, FC bias words.
- N_FMAP, 1024, input feature-map pixels per image.
- TIMEOUT, 65535, maximum RUN cycles before error.
- CNT_BW, 16, width of the beat and timeout counters (≥ clog2 of the largest of the above).

Ports:
- clk, in, 1, sole clock.
- user_reset, in, 1, synchronous active-high reset.
- i_start, in, 1, single-cycle pulse: begin a job (ignored unless IDLE or DONE).
- i_reload_w, in, 1, sampled with i_start: 1 = load weights+biases, 0 = reuse the resident set.
- i_abort, in, 1, return to IDLE from any state.
- s_data, in, DATA_BW, stream word.
- s_valid, in, 1, stream word valid.
- s_ready, out, 1, sequencer accepts the word.
- o_data, out, DATA_BW, word to the engine.
- o_weight_we, out, 1, weight-buffer write strobe.
- o_bias_we, out, 1, bias-buffer write strobe.
- o_fmap_we, out, 1, fmap-buffer write strobe.
- o_ce, out, 1, engine clock-enable.
- i_cls_en, in, 1, engine result-valid.
- i_cls_result, in, 4, engine class index.
- i_cls_end, in, 1, engine job-complete.
- o_result, out, 4, captured class.
- o_busy, out, 1, state ∉ {IDLE, DONE}.
- o_done, out, 1, level: DONE reached with a valid result.
- o_err, out, 1, level: timeout, or end without result.
- o_wloaded, out, 1, a full weight+bias set is resident.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, wloaded 0.
- States: IDLE, LOAD_W, LOAD_B, LOAD_F, RUN, DONE.
- Start from IDLE or DONE:
  - If i_reload_w = 1 or wloaded = 0: go to LOAD_W and clear wloaded.
  - Otherwise go to LOAD_F.
  - Start also clears o_done, o_err and o_result.
- Transfers:
  - s_ready = 1 exactly in LOAD_W, LOAD_B and LOAD_F. It is combinational from state only and never depends on s_valid.
  - A beat is s_valid && s_ready.
  - A beat at cycle t registers o_data = s_data and the matching strobe at t+1. The strobe is high for one cycle per beat.
  - Exactly one strobe is ever high at a time.
- Beat counting:
  - The beat counter increments per beat.
  - On the beat where the count = N−1: clear the counter and advance LOAD_W→LOAD_B→LOAD_F→RUN.
  - Set wloaded when leaving LOAD_B.
  - Gaps (s_valid = 0) stall with no strobe and no state change.
- o_ce: registered. It is 1 from the first cycle after leaving IDLE through the last cycle of RUN, and 0 in IDLE and DONE.
- RUN:
  - The timeout counter increments every cycle.
  - i_cls_en = 1: capture i_cls_result into o_result and set a got flag.
  - i_cls_end = 1: go to DONE. o_done = got-or-same-cycle-en; otherwise o_err = 1.
  - If i_cls_en and i_cls_end arrive in the same cycle, the result is captured and o_done = 1.
  - Timeout counter = TIMEOUT−1 without end: go to DONE, o_err = 1, o_done = 0.
- Engine outputs outside RUN are ignored.
- DONE holds o_result, o_done and o_err until the next start or abort.
- i_abort (after reset, highest priority) in any state:
  - Next cycle: state IDLE, strobes 0, o_ce 0, counters 0, o_done and o_err 0.
  - If aborted during LOAD_W or LOAD_B: wloaded = 0.
  - If aborted during LOAD_F or RUN: wloaded is kept.
- i_start while busy is ignored. i_start and i_abort in the same cycle: abort wins.
- Width rule: s_data passes through unmodified. The engine uses its low W_BW/B_BW/I_BW bits.

Decomposition:
- Shared package/header: state encodings, default counts (N_WEIGHT = 3220, N_BIAS = 10, N_FMAP = 1024), and a clog2-derived CNT_BW. Place these alongside the existing parameter include.
- One natural sub-module: lenet5_beat_counter (load value N−1, enable, clear, terminal-count flag). It is instantiated twice: once for beats, once for timeout.

Test Plan:
- Cold start, i_reload_w = 0, back-to-back valid:
  - Expect 3220 o_weight_we, 10 o_bias_we, 1024 o_fmap_we, each strobe's o_data equal to the word accepted one cycle earlier.
  - o_wloaded rises after bias beat 10.
  - RUN is entered after fmap beat 1024.
- Warm start with o_wloaded = 1, i_reload_w = 0:
  - First beat yields o_fmap_we; no weight or bias strobe occurs.
- In RUN, drive i_cls_en with result 7, then i_cls_end 20 cycles later:
  - o_result = 7, o_done = 1, o_err = 0, o_ce drops the cycle after end.
  - Also drive en and end in the same cycle with result 3: o_result = 3, o_done = 1.
- Random s_valid gaps (50%) during a load:
  - Strobe count is still exact and no strobe is issued in gap cycles.
  - In RUN with TIMEOUT = 100 and no end: o_err = 1 at RUN cycle 100.
- Assert i_abort at weight beat 1500:
  - IDLE next cycle, o_wloaded = 0.
  - A restart with i_reload_w = 0 goes to LOAD_W.
  - i_start during LOAD_F is ignored, with counts unchanged.
- Assert user_reset mid-RUN:
  - All outputs 0 next cycle.
  - Engine i_cls_end after reset has no effect.

Source files
------------

// File: rtl/lenet5_load_sequencer_pkg.sv
// Shared types and default sizing for the LeNet-5 load sequencer.
package lenet5_load_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_B,
        ST_LOAD_F,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    localparam int DEF_DATA_BW  = 16;
    localparam int DEF_N_WEIGHT = 3220;
    localparam int DEF_N_BIAS   = 10;
    localparam int DEF_N_FMAP   = 1024;
    localparam int DEF_TIMEOUT  = 65535;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_CNT_BW = $clog2(
        max2(max2(DEF_N_WEIGHT, DEF_N_FMAP), DEF_TIMEOUT) + 1);

endpackage

// File: rtl/lenet5_beat_counter.sv
// Wrapping counter with programmable terminal value, clear and enable.
module lenet5_beat_counter #(
    parameter int CNT_BW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [CNT_BW-1:0] i_last,
    output logic              o_tc
);

    logic [CNT_BW-1:0] count_q;
    logic [CNT_BW-1:0] count_d;

    assign o_tc = (count_q == i_last);

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = o_tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lenet5_load_sequencer.sv
// Routes the host word stream into weight, bias and fmap buffers,
// then supervises the engine run and captures its class result.
module lenet5_load_sequencer
    import lenet5_load_sequencer_pkg::*;
#(
    parameter int DATA_BW  = DEF_DATA_BW,
    parameter int N_WEIGHT = DEF_N_WEIGHT,
    parameter int N_BIAS   = DEF_N_BIAS,
    parameter int N_FMAP   = DEF_N_FMAP,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_BW   = DEF_CNT_BW
) (
    input  logic               clk,
    input  logic               user_reset,
    input  logic               i_start,
    input  logic               i_reload_w,
    input  logic               i_abort,
    input  logic [DATA_BW-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [DATA_BW-1:0] o_data,
    output logic               o_weight_we,
    output logic               o_bias_we,
    output logic               o_fmap_we,
    output logic               o_ce,
    input  logic               i_cls_en,
    input  logic [3:0]         i_cls_result,
    input  logic               i_cls_end,
    output logic [3:0]         o_result,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic               o_wloaded
);

    localparam logic [CNT_BW-1:0] W_LAST  = CNT_BW'(N_WEIGHT - 1);
    localparam logic [CNT_BW-1:0] B_LAST  = CNT_BW'(N_BIAS - 1);
    localparam logic [CNT_BW-1:0] F_LAST  = CNT_BW'(N_FMAP - 1);
    localparam logic [CNT_BW-1:0] TO_LAST = CNT_BW'(TIMEOUT - 1);

    seq_state_e         state_q, state_d;
    logic [DATA_BW-1:0] data_q, data_d;
    logic               wwe_q, wwe_d;
    logic               bwe_q, bwe_d;
    logic               fwe_q, fwe_d;
    logic               ce_q, ce_d;
    logic [3:0]         result_q, result_d;
    logic               got_q, got_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               wloaded_q, wloaded_d;

    logic               beat;
    logic               start_ok;
    logic               any_en;
    logic [CNT_BW-1:0]  ld_last;
    logic               ld_tc;
    logic               to_tc;

    assign s_ready = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B)
                  || (state_q == ST_LOAD_F);
    assign beat     = s_valid && s_ready;
    assign start_ok = i_start
                   && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign any_en   = got_q || i_cls_en;

    always_comb begin
        case (state_q)
            ST_LOAD_B: ld_last = B_LAST;
            ST_LOAD_F: ld_last = F_LAST;
            default:   ld_last = W_LAST;
        endcase
    end

    lenet5_beat_counter #(.CNT_BW(CNT_BW)) u_beat_cnt (
        .clk     (clk),
        .rst     (user_reset),
        .i_clear (i_abort || start_ok),
        .i_en    (beat),
        .i_last  (ld_last),
        .o_tc    (ld_tc)
    );

    lenet5_beat_counter #(.CNT_BW(CNT_BW)) u_timeout_cnt (
        .clk     (clk),
        .rst     (user_reset),
        .i_clear (i_abort || (state_q != ST_RUN)),
        .i_en    (state_q == ST_RUN),
        .i_last  (TO_LAST),
        .o_tc    (to_tc)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        wwe_d     = 1'b0;
        bwe_d     = 1'b0;
        fwe_d     = 1'b0;
        result_d  = result_q;
        got_d     = got_q;
        done_d    = done_q;
        err_d     = err_q;
        wloaded_d = wloaded_q;

        if (i_abort) begin
            state_d = ST_IDLE;
            got_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            if ((state_q == ST_LOAD_W) || (state_q == ST_LOAD_B)) begin
                wloaded_d = 1'b0;
            end
        end else begin
            if (beat) begin
                data_d = s_data;
                wwe_d  = (state_q == ST_LOAD_W);
                bwe_d  = (state_q == ST_LOAD_B);
                fwe_d  = (state_q == ST_LOAD_F);
            end
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        result_d = '0;
                        got_d    = 1'b0;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        if (i_reload_w || !wloaded_q) begin
                            state_d   = ST_LOAD_W;
                            wloaded_d = 1'b0;
                        end else begin
                            state_d = ST_LOAD_F;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (beat && ld_tc) state_d = ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    if (beat && ld_tc) begin
                        state_d   = ST_LOAD_F;
                        wloaded_d = 1'b1;
                    end
                end
                ST_LOAD_F: begin
                    if (beat && ld_tc) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (i_cls_en) begin
                        result_d = i_cls_result;
                        got_d    = 1'b1;
                    end
                    // End wins over a timeout landing in the same cycle.
                    if (i_cls_end) begin
                        state_d = ST_DONE;
                        done_d  = any_en;
                        err_d   = !any_en;
                    end else if (to_tc) begin
                        state_d = ST_DONE;
                        done_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        ce_d = (state_d == ST_LOAD_W) || (state_d == ST_LOAD_B)
            || (state_d == ST_LOAD_F) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (user_reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            wwe_q     <= 1'b0;
            bwe_q     <= 1'b0;
            fwe_q     <= 1'b0;
            ce_q      <= 1'b0;
            result_q  <= '0;
            got_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wloaded_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            wwe_q     <= wwe_d;
            bwe_q     <= bwe_d;
            fwe_q     <= fwe_d;
            ce_q      <= ce_d;
            result_q  <= result_d;
            got_q     <= got_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wloaded_q <= wloaded_d;
        end
    end

    assign o_data      = data_q;
    assign o_weight_we = wwe_q;
    assign o_bias_we   = bwe_q;
    assign o_fmap_we   = fwe_q;
    assign o_ce        = ce_q;
    assign o_result    = result_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_wloaded   = wloaded_q;
    assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_lenet5_load_sequencer.sv
// Directed-random bench for lenet5_load_sequencer with a beat-level
// reference model of the weight/bias/fmap routing and run outcome.
module tb_lenet5_load_sequencer;

    localparam int NW = 3220;
    localparam int NB = 10;
    localparam int NF = 1024;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        user_reset;
    logic        i_start;
    logic        i_reload_w;
    logic        i_abort;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] o_data;
    logic        o_weight_we;
    logic        o_bias_we;
    logic        o_fmap_we;
    logic        o_ce;
    logic        i_cls_en;
    logic [3:0]  i_cls_result;
    logic        i_cls_end;
    logic [3:0]  o_result;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_wloaded;

    int vectors = 0;
    int miscompares = 0;
    bit exp_wl = 1'b0;

    always #5 clk = ~clk;

    lenet5_load_sequencer #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .user_reset   (user_reset),
        .i_start      (i_start),
        .i_reload_w   (i_reload_w),
        .i_abort      (i_abort),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .o_data       (o_data),
        .o_weight_we  (o_weight_we),
        .o_bias_we    (o_bias_we),
        .o_fmap_we    (o_fmap_we),
        .o_ce         (o_ce),
        .i_cls_en     (i_cls_en),
        .i_cls_result (i_cls_result),
        .i_cls_end    (i_cls_end),
        .o_result     (o_result),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_wloaded    (o_wloaded)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {3'b0, o_data, o_weight_we, o_bias_we, o_fmap_we, o_ce,
                  o_result, o_busy, o_done, o_err, o_wloaded, s_ready}, 0);
    endtask

    task automatic start_job(input bit reload, output bit with_w);
        @(negedge clk);
        i_start    = 1'b1;
        i_reload_w = reload;
        with_w     = reload || !exp_wl;
        if (with_w) exp_wl = 1'b0;
    endtask

    // Streams one job's words; the model decides which buffer each
    // accepted word belongs to purely from its position in the job.
    task automatic do_load(input bit with_w, input int gap,
                           input int stop_at, input int start_at);
        int base  = with_w ? 0 : NW + NB;
        int total = with_w ? NW + NB + NF : NF;
        int limit = (stop_at >= 0) ? stop_at : total;
        int got   = 0;
        int guard = 0;
        int pidx  = -1;
        bit pend  = 1'b0;
        logic [2:0]  pk = '0;
        logic [15:0] pd = '0;
        forever begin
            @(negedge clk);
            if (pend && pidx == NW + NB - 1) exp_wl = 1'b1;
            chk("strobe", {o_weight_we, o_bias_we, o_fmap_we},
                pend ? pk : 3'b000);
            if (pend) chk("data", o_data, pd);
            chk("wloaded", o_wloaded, exp_wl);
            chk("ce_load", o_ce, 1);
            chk("done_err_load", {o_done, o_err}, 0);
            chk("result_load", o_result, 0);
            i_start = 1'b0;
            if (got == limit) begin
                s_valid   = 1'b0;
                i_cls_en  = 1'b0;
                i_cls_end = 1'b0;
                break;
            end
            if (++guard > 20000) begin
                chk("load_bound", guard, 0);
                break;
            end
            chk("s_ready_load", s_ready, 1);
            i_start      = (got == start_at);
            s_valid      = ($urandom_range(99) >= gap);
            s_data       = 16'($urandom);
            i_cls_en     = 1'($urandom);
            i_cls_end    = 1'($urandom);
            i_cls_result = 4'($urandom);
            pend = s_valid;
            if (pend) begin
                pidx = base + got;
                pk = (pidx < NW) ? 3'b100 :
                     (pidx < NW + NB) ? 3'b010 : 3'b001;
                pd = s_data;
                got++;
            end
        end
        if (stop_at < 0) begin
            chk("run_ready", s_ready, 0);
            chk("run_busy", o_busy, 1);
        end
    endtask

    task automatic run_result(input int dly, input logic [3:0] res,
                              input bit same);
        i_cls_en     = 1'b1;
        i_cls_result = res;
        i_cls_end    = same;
        if (!same) begin
            @(negedge clk);
            i_cls_en     = 1'b0;
            i_cls_result = 4'($urandom);
            repeat (dly - 1) begin
                @(negedge clk);
                chk("run_ce", o_ce, 1);
                chk("run_done", {o_done, o_err}, 0);
                i_cls_result = 4'($urandom);
            end
            i_cls_end = 1'b1;
        end
        @(negedge clk);
        i_cls_en  = 1'b0;
        i_cls_end = 1'b0;
        chk("end_status", {o_done, o_err, o_ce, o_busy}, 4'b1000);
        chk("end_result", o_result, res);
        repeat (3) @(negedge clk);
        chk("hold_status", {o_done, o_err}, 2'b10);
        chk("hold_result", o_result, res);
    endtask

    initial begin
        bit ww;
        int n;
        logic [3:0] r;

        user_reset   = 1'b1;
        i_start      = 1'b0;
        i_reload_w   = 1'b0;
        i_abort      = 1'b0;
        s_data       = '0;
        s_valid      = 1'b0;
        i_cls_en     = 1'b0;
        i_cls_result = '0;
        i_cls_end    = 1'b0;
        repeat (3) @(negedge clk);
        user_reset = 1'b0;
        chk_all_zero("reset");

        // Cold start: full weight/bias/fmap load, then a result.
        start_job(1'b0, ww);
        do_load(ww, 0, -1, -1);
        run_result(20, 4'd7, 1'b0);

        // Warm start: fmap only; en and end together.
        start_job(1'b0, ww);
        do_load(ww, 0, -1, -1);
        run_result(0, 4'd3, 1'b1);

        // Gappy full reload, then run into the timeout.
        start_job(1'b1, ww);
        do_load(ww, 50, -1, -1);
        n = 0;
        while (!o_err && n < TO + 10) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, TO);
        chk("timeout_status", {o_done, o_err, o_busy, o_ce}, 4'b0100);

        // Abort mid weight load; abort beats a simultaneous beat.
        start_job(1'b1, ww);
        do_load(ww, 0, 1500, -1);
        i_abort = 1'b1;
        s_valid = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        s_valid = 1'b0;
        i_start = 1'b0;
        exp_wl  = 1'b0;
        chk("abort_state", {o_busy, s_ready, o_weight_we, o_bias_we,
                            o_fmap_we, o_ce, o_done, o_err}, 0);
        chk("abort_wloaded", o_wloaded, exp_wl);

        // Restart without reload must reload weights; start in LOAD_F ignored.
        start_job(1'b0, ww);
        do_load(ww, 30, -1, NW + NB + 500);
        r = 4'($urandom);
        run_result(5, r, 1'b0);

        // Reset in the middle of a run.
        start_job(1'b0, ww);
        do_load(ww, 0, -1, -1);
        repeat (5) @(negedge clk);
        user_reset = 1'b1;
        @(negedge clk);
        user_reset = 1'b0;
        exp_wl     = 1'b0;
        chk_all_zero("reset_mid_run");
        i_cls_en     = 1'b1;
        i_cls_end    = 1'b1;
        i_cls_result = 4'd5;
        @(negedge clk);
        i_cls_en  = 1'b0;
        i_cls_end = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset_end");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
